// File: rtl/mbist_result_unloader.sv
// mbist_result_unloader: captures the MBIST result word on done rising, checks it against a golden signature, unloads it MSB-first as a byte stream
//   clk, rst                       clock, async active-high reset
//   MBIST_done, MBIST_data         completion level and result word from top_mbist
//   byte_ready                     consumer accepts byte_out
//   byte_out, byte_valid           result byte stream, MSB-first
//   busy                           unload in progress
//   result_pass                    last captured word matched EXPECTED
//   unload_done                    one-cycle pulse after the last byte handshake
//   overrun                        sticky, a completion arrived while not idle
module mbist_result_unloader #(
  parameter int DATA_W = 56,
  parameter logic [DATA_W-1:0] EXPECTED = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MBIST_done,
  input  logic [DATA_W-1:0] MBIST_data,
  input  logic              byte_ready,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  output logic              busy,
  output logic              result_pass,
  output logic              unload_done,
  output logic              overrun
);
  localparam int NBYTES = DATA_W / 8;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
  state_t            state_q;
  logic              done_q, busy_q, pass_q, fin_q, ovr_q;
  logic [DATA_W-1:0] shreg_q;
  logic [CW-1:0]     cnt_q;
  logic              start;
  assign start       = MBIST_done & ~done_q;
  assign byte_out    = shreg_q[DATA_W-1 -: 8];
  assign byte_valid  = busy_q;
  assign busy        = busy_q;
  assign result_pass = pass_q;
  assign unload_done = fin_q;
  assign overrun     = ovr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fin_q   <= 1'b0;
      ovr_q   <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= MBIST_done;
      fin_q  <= 1'b0;
      if (start && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (start) begin
          shreg_q <= MBIST_data;
          cnt_q   <= CW'(NBYTES - 1);
          pass_q  <= MBIST_data == EXPECTED;
          busy_q  <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (byte_ready) begin
          shreg_q <= shreg_q << 8;
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            fin_q   <= 1'b1;
            state_q <= FIN;
          end else cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
